// File: rtl/mem_access.sv
// mem_access: load/store access sequencer between execute and data memory.
// Turns one request into a single word-aligned memory transaction with
// byte-lane enables and lane-shifted store data, right-aligns load data,
// and reports misaligned / illegal-width requests without touching memory.
// Optional feature: define MEM_ACCESS_TIMEOUT_EN to abort an access that
// sees no mem_ready for 255 cycles (reported as done with err=1).
module mem_access #(
    parameter int F3_LEN = 3,
    parameter int N      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_store,
    input  logic [F3_LEN-1:0] funct3,
    input  logic [N-1:0]      addr,
    input  logic [N-1:0]      wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [N-1:0]      rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [N-1:0]      mem_addr,
    output logic [N/8-1:0]    mem_be,
    output logic [N-1:0]      mem_wdata,
    input  logic              mem_ready,
    input  logic [N-1:0]      mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        FAULT  = 2'd3
    } state_t;

    state_t           state_q, state_d;

    // Registered request fields, captured when a start is accepted.
    logic             we_q;
    logic [1:0]       off_q;
    logic [N-3:0]     waddr_q;
    logic [N/8-1:0]   be_q;
    logic [N-1:0]     wdata_q;
    logic [N-1:0]     rdata_q;

    // A fault spends two cycles in FAULT so that done/err land two cycles
    // after the start, matching the successful path's fastest response.
    logic             fault_phase_q;

    logic             accept;
    logic             illegal;
    logic             misaligned;
    logic [N/8-1:0]   be_d;
    logic             resp_err;

`ifdef MEM_ACCESS_TIMEOUT_EN
    logic [7:0]       cnt_q;
    logic             timeout_err_q;
    logic             timeout_hit;
`endif

    assign accept = (state_q == IDLE) && start;

    // Request decode: legality, alignment and byte-lane enables.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first,
        // so no path through the case statement can infer a latch.
        illegal    = 1'b0;
        misaligned = 1'b0;
        be_d       = '1;
        if (is_store) begin
            illegal = funct3[2] || (funct3[1:0] == 2'b11);
        end else begin
            illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end
        case (funct3[1:0])
            2'b00: be_d = {{(N/8-1){1'b0}}, 1'b1} << addr[1:0];
            2'b01: begin
                be_d       = {{(N/8-2){1'b0}}, 2'b11} << addr[1:0];
                misaligned = addr[0];
            end
            2'b10: misaligned = (addr[1:0] != 2'b00);
            default: be_d = '1;
        endcase
    end

    // Request capture, fault phase and load-data capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q          <= 1'b0;
            off_q         <= 2'b00;
            waddr_q       <= '0;
            be_q          <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            fault_phase_q <= 1'b0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            if (accept) begin
                we_q    <= is_store;
                off_q   <= addr[1:0];
                waddr_q <= addr[N-1:2];
                be_q    <= be_d;
                wdata_q <= wdata << {addr[1:0], 3'b000};
            end
            if ((state_q == ACCESS) && mem_ready && !we_q) begin
                rdata_q <= mem_rdata >> {off_q, 3'b000};
            end
            fault_phase_q <= (state_q == FAULT) && !fault_phase_q;
        end
    end

`ifdef MEM_ACCESS_TIMEOUT_EN
    // The access gives up once the 255th ready-less ACCESS cycle completes.
    assign timeout_hit = (cnt_q == 8'd254) && !mem_ready;

    // Timeout counter: cleared on entry to ACCESS, counts stalled cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= 8'd0;
            timeout_err_q <= 1'b0;
        end else begin
            if (accept) begin
                cnt_q <= 8'd0;
            end else if ((state_q == ACCESS) && !mem_ready) begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (state_q == ACCESS) begin
                timeout_err_q <= timeout_hit;
            end
        end
    end

    assign resp_err = timeout_err_q;
`else
    assign resp_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (illegal || misaligned) ? FAULT : ACCESS;
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    state_d = RESP;
                end
`ifdef MEM_ACCESS_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_d = RESP;
                end
`endif
            end
            RESP:    state_d = IDLE;
            FAULT:   state_d = fault_phase_q ? IDLE : FAULT;
            default: state_d = IDLE;
        endcase
    end

    // Outputs, decoded from registered state only.
    always_comb begin
        busy      = (state_q != IDLE);
        mem_req   = (state_q == ACCESS);
        mem_we    = (state_q == ACCESS) && we_q;
        mem_addr  = {waddr_q, 2'b00};
        mem_be    = be_q;
        mem_wdata = wdata_q;
        rdata     = rdata_q;
        done      = (state_q == RESP) || ((state_q == FAULT) && fault_phase_q);
        err       = ((state_q == RESP) && resp_err) || ((state_q == FAULT) && fault_phase_q);
    end

endmodule

// File: doc/mem_access.md
# mem_access

Load/store access sequencer between the execute stage and data memory. It turns one load or store request into a single word-aligned memory transaction: byte-lane enables, write-data lane shifting, and a ready/request handshake. On loads it right-aligns the returned word and holds it for the load sign/zero-extension stage. It detects misaligned and illegal-width accesses without touching memory and stalls the pipeline while a transaction is in flight.

## Interface
- F3_LEN, 3: funct3 width.
- N, 32: data/address width; fixed at 32 for RV32.
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  request strobe; sampled only in IDLE.
- is_store  input  1  1 = store, 0 = load; sampled with start.
- funct3  input  F3_LEN  access width/type; sampled with start.
- addr  input  N  byte address; sampled with start.
- wdata  input  N  store data, right-aligned; sampled with start.
- busy  output  1  high in every state except IDLE; pipeline stall.
- done  output  1  one-cycle pulse when the access completes or faults.
- err  output  1  valid with done: 1 = misaligned, illegal funct3, or timeout.
- rdata  output  N  right-aligned load word for the extension stage; held until the next load completes.
- mem_req  output  1  memory request; held until accepted.
- mem_we  output  1  write enable, valid with mem_req.
- mem_addr  output  N  {addr[N-1:2], 2'b00}.
- mem_be  output  N/8  byte enables.
- mem_wdata  output  N  lane-shifted store data.
- mem_ready  input  1  memory accept/response; the access completes in a cycle with mem_req && mem_ready.
- mem_rdata  input  N  read data, valid when mem_ready is high on a load.

## Operation
- FSM states: IDLE, ACCESS, RESP, FAULT. Reset state is IDLE.
- In IDLE, start=1 latches the request.
  - Illegal or misaligned request: go to FAULT.
  - Otherwise: go to ACCESS.
- Illegal funct3: loads with 011, 110 or 111; stores with anything other than 000, 001 or 010.
- Misaligned: halfword (001, 101) with addr[0]=1; word (010) with addr[1:0]≠0.
- ACCESS:
  - mem_req=1, with mem_we, mem_addr, mem_be and mem_wdata driven from registered request fields. All are stable until accepted.
  - On mem_ready=1, go to RESP. For loads, capture rdata = mem_rdata >> (8·addr[1:0]).
- RESP: done=1, err=0, then return to IDLE.
- FAULT: done=1, err=1, no mem_req, then return to IDLE. rdata is unchanged.
- mem_be encoding:
  - Byte: 4'b0001 << addr[1:0].
  - Half: 4'b0011 << addr[1:0].
  - Word: 4'b1111.
  - Loads drive mem_be the same way.
- mem_wdata = wdata << (8·addr[1:0]). Bits outside the enabled lanes are don't-care.
- rdata holds the full shifted word, not masked. Masking and extension happen downstream.
- start while busy is ignored; no queueing.
- Reset mid-operation:
  - All outputs return to reset values immediately.
  - The in-flight memory transaction is abandoned.
  - A mem_ready arriving after reset is ignored.
- Reset values: busy=0, done=0, err=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, rdata=0.

## Timing
- Start accepted in cycle 0. mem_req is high from cycle 1 (registered; no combinational start→mem_req path).
- If mem_ready is high in cycle k≥1, done and the new rdata are visible in cycle k+1.
- busy is high from cycle 1 through the done cycle inclusive, and low the cycle after.
- Minimum access: 3 cycles from start to the next accepted start.
- Fault path: done=err=1 in cycle 2, with no memory activity.
- mem_ready outside ACCESS has no effect.
- No combinational path from mem_ready or mem_rdata to any output.

## Configuration
- MEM_ACCESS_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle without mem_ready.
  - On reaching 255, drop mem_req and go to RESP with err=1. rdata is not updated.
- Not defined: no counter. ACCESS waits indefinitely for mem_ready.

## Test plan
- LB, addr=0x103, mem_ready in cycle 1, mem_rdata=0x80AABBCC:
  - mem_addr=0x100, mem_be=4'b1000.
  - rdata=0x00000080 with done in cycle 2.
- SH, addr=0x202, wdata=0x0000BEEF, mem_ready delayed 3 cycles:
  - mem_req held cycles 1–4, mem_we=1, mem_be=4'b1100.
  - mem_wdata[31:16]=0xBEEF, done in cycle 5.
- LW, addr=0x101:
  - no mem_req ever asserted.
  - done=err=1 in cycle 2, busy low in cycle 3.
- Load with funct3=3'b110: FAULT, err=1; also repeat start during busy and confirm it is ignored.
- Reset asserted mid-ACCESS:
  - mem_req and busy drop asynchronously.
  - A late mem_ready produces no done.
- With MEM_ACCESS_TIMEOUT_EN defined and mem_ready tied low: done=err=1 after 255 ACCESS cycles, rdata unchanged.
